// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : wb_arbiter_if
// Brief  : Result-source handshake bundle and regfile write-port bundle
//          for the writeback arbiter.
// Rev    : 1.0
// ============================================================================
interface wb_arbiter_if #(
    parameter int S_WIDTH = 32,
    parameter int S_INDEX = 5,
    parameter int NUM_SRC = 4,
    parameter int S_TAG   = 6
);
    logic                       flush;
    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC-1:0]         src_ready;
    logic [NUM_SRC*S_INDEX-1:0] src_dest;
    logic [NUM_SRC*S_WIDTH-1:0] src_data;
    logic [NUM_SRC*S_TAG-1:0]   src_tag;
    logic                       ld_a;
    logic                       ld_b;
    logic [S_INDEX-1:0]         dest_a;
    logic [S_INDEX-1:0]         dest_b;
    logic [S_WIDTH-1:0]         in_a;
    logic [S_WIDTH-1:0]         in_b;
    logic                       prefer_a;

    modport master (
        output flush, src_valid, src_dest, src_data, src_tag,
        input  src_ready, ld_a, ld_b, dest_a, dest_b, in_a, in_b, prefer_a
    );

    modport slave (
        input  flush, src_valid, src_dest, src_data, src_tag,
        output src_ready, ld_a, ld_b, dest_a, dest_b, in_a, in_b, prefer_a
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_arbiter
// Brief  : Round-robin writeback arbiter, up to two results per cycle into the
//          regfile's two write ports. Optional macro WB_DROP_R0_EN suppresses
//          writes to register 0.
// Rev    : 1.0
// ============================================================================
module wb_arbiter #(
    parameter int S_WIDTH = 32,
    parameter int S_INDEX = 5,
    parameter int NUM_SRC = 4,
    parameter int S_TAG   = 6
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);
    localparam int               PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [PTR_W:0]   C_NUM  = (PTR_W+1)'(NUM_SRC);
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(NUM_SRC - 1);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_ld_a, r_ld_b, r_prefer;
    logic [S_INDEX-1:0] r_dest_a, r_dest_b;
    logic [S_WIDTH-1:0] r_in_a, r_in_b;

    logic [NUM_SRC-1:0] w_ready;
    logic               w_has_a, w_has_b;
    logic [PTR_W-1:0]   w_idx_a, w_idx_b, w_last, w_next_ptr;
    logic [PTR_W:0]     w_pos;
    logic [S_INDEX-1:0] w_dest_a, w_dest_b;
    logic [S_WIDTH-1:0] w_data_a, w_data_b;
    logic [S_TAG-1:0]   w_tag_a, w_tag_b, w_diff;
    logic               w_young, w_wr_a, w_wr_b, w_prefer;

    // Scan from the round-robin pointer; first two valid sources win A then B.
    always_comb begin
        w_ready = '0;
        w_has_a = 1'b0;
        w_has_b = 1'b0;
        w_idx_a = '0;
        w_idx_b = '0;
        w_pos   = '0;
        if (!(rst || bus.flush)) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                w_pos = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
                if (w_pos >= C_NUM) begin
                    w_pos = w_pos - C_NUM;
                end
                if (bus.src_valid[w_pos[PTR_W-1:0]] && !w_has_b) begin
                    if (!w_has_a) begin
                        w_has_a = 1'b1;
                        w_idx_a = w_pos[PTR_W-1:0];
                    end else begin
                        w_has_b = 1'b1;
                        w_idx_b = w_pos[PTR_W-1:0];
                    end
                    w_ready[w_pos[PTR_W-1:0]] = 1'b1;
                end
            end
        end
    end

    assign w_dest_a = bus.src_dest[w_idx_a*S_INDEX +: S_INDEX];
    assign w_dest_b = bus.src_dest[w_idx_b*S_INDEX +: S_INDEX];
    assign w_data_a = bus.src_data[w_idx_a*S_WIDTH +: S_WIDTH];
    assign w_data_b = bus.src_data[w_idx_b*S_WIDTH +: S_WIDTH];
    assign w_tag_a  = bus.src_tag[w_idx_a*S_TAG +: S_TAG];
    assign w_tag_b  = bus.src_tag[w_idx_b*S_TAG +: S_TAG];

    // Wrapping tag compare: A is younger when A-B is a small positive distance.
    assign w_diff  = w_tag_a - w_tag_b;
    assign w_young = (w_diff != '0) && !w_diff[S_TAG-1];

`ifdef WB_DROP_R0_EN
    assign w_wr_a = w_has_a && (w_dest_a != '0);
    assign w_wr_b = w_has_b && (w_dest_b != '0);
`else
    assign w_wr_a = w_has_a;
    assign w_wr_b = w_has_b;
`endif

    assign w_prefer   = w_wr_a && w_wr_b && w_young;
    assign w_last     = w_has_b ? w_idx_b : w_idx_a;
    assign w_next_ptr = (w_last == C_LAST) ? '0 : w_last + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_a   <= 1'b0;
            r_ld_b   <= 1'b0;
            r_prefer <= 1'b0;
            r_dest_a <= '0;
            r_dest_b <= '0;
            r_in_a   <= '0;
            r_in_b   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_ld_a   <= w_wr_a;
            r_ld_b   <= w_wr_b;
            r_prefer <= w_prefer;
            if (w_has_a) begin
                r_dest_a <= w_dest_a;
                r_in_a   <= w_data_a;
                r_rr_ptr <= w_next_ptr;
            end
            if (w_has_b) begin
                r_dest_b <= w_dest_b;
                r_in_b   <= w_data_b;
            end
        end
    end

    assign bus.src_ready = w_ready;
    assign bus.ld_a      = r_ld_a;
    assign bus.ld_b      = r_ld_b;
    assign bus.dest_a    = r_dest_a;
    assign bus.dest_b    = r_dest_b;
    assign bus.in_a      = r_in_a;
    assign bus.in_b      = r_in_b;
    assign bus.prefer_a  = r_prefer;
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_arbiter
// Brief  : Directed vector table plus randomized reference-model checks.
// Rev    : 1.0
// ============================================================================
module tb_wb_arbiter;
    localparam int N = 4;
`ifdef WB_DROP_R0_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.S_WIDTH(32), .S_INDEX(5), .NUM_SRC(N), .S_TAG(6)) bus ();
    wb_arbiter #(.S_WIDTH(32), .S_INDEX(5), .NUM_SRC(N), .S_TAG(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        flush;
        logic [19:0] dest;
        logic [23:0] tag;
        logic [3:0]  e_ready;
        logic        e_ld_a, e_ld_b;
        logic [4:0]  e_da, e_db;
        logic [31:0] e_ia, e_ib;
        logic        e_pref;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[13];

    function automatic logic [31:0] dv(int n, int i);
        if (n == 4 && i == 2) return 32'hDEADBEEF;
        return 32'hC0DE0000 | 32'(n << 8) | 32'(i);
    endfunction

    function automatic vec_t mk(logic [3:0] v, logic f, logic [19:0] d, logic [23:0] t,
                                logic [3:0] er, logic la, logic lb, logic [4:0] da,
                                logic [4:0] db, logic [31:0] ia, logic [31:0] ib, logic p);
        vec_t r;
        r.valid = v; r.flush = f; r.dest = d; r.tag = t; r.e_ready = er;
        r.e_ld_a = la; r.e_ld_b = lb; r.e_da = da; r.e_db = db;
        r.e_ia = ia; r.e_ib = ib; r.e_pref = p;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(logic la, logic lb, logic [4:0] da, logic [4:0] db,
                            logic [31:0] ia, logic [31:0] ib, logic p);
        chk("ld_a", 32'(bus.ld_a), 32'(la));
        chk("ld_b", 32'(bus.ld_b), 32'(lb));
        chk("dest_a", 32'(bus.dest_a), 32'(da));
        chk("dest_b", 32'(bus.dest_b), 32'(db));
        chk("in_a", bus.in_a, ia);
        chk("in_b", bus.in_b, ib);
        chk("prefer_a", 32'(bus.prefer_a), 32'(p));
    endtask

    // Reference model state for the random phase
    int          m_rr;
    logic        m_ld_a, m_ld_b, m_pref;
    logic [4:0]  m_da, m_db;
    logic [31:0] m_ia, m_ib;

    initial begin
        bus.flush = 1'b0; bus.src_valid = 4'hF;
        bus.src_dest = '0; bus.src_data = '0; bus.src_tag = '0;

        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            #3 chk("reset_ready", 32'(bus.src_ready), 32'h0);
            @(posedge clk); #1;
            chk_outs(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        end
        rst = 1'b0;

        tbl[0]  = mk(4'hF, 0, {5'd13,5'd12,5'd11,5'd10}, {6'd3,6'd2,6'd1,6'd0},
                     4'b0011, 1, 1, 10, 11, dv(0,0), dv(0,1), 0);
        tbl[1]  = mk(4'hF, 0, {5'd13,5'd12,5'd11,5'd10}, {6'd3,6'd2,6'd1,6'd0},
                     4'b1100, 1, 1, 12, 13, dv(1,2), dv(1,3), 0);
        tbl[2]  = mk(4'hF, 0, {5'd13,5'd12,5'd11,5'd10}, {6'd3,6'd2,6'd9,6'd12},
                     4'b0011, 1, 1, 10, 11, dv(2,0), dv(2,1), 1);
        tbl[3]  = mk(4'hF, 0, {5'd13,5'd12,5'd11,5'd10}, {6'd3,6'd2,6'd1,6'd0},
                     4'b1100, 1, 1, 12, 13, dv(3,2), dv(3,3), 0);
        tbl[4]  = mk(4'b0100, 0, {5'd13,5'd7,5'd11,5'd10}, {6'd0,6'd3,6'd0,6'd0},
                     4'b0100, 1, 0, 7, 13, 32'hDEADBEEF, dv(3,3), 0);
        tbl[5]  = mk(4'b0011, 0, {5'd0,5'd0,5'd5,5'd5}, {6'd0,6'd0,6'd1,6'd62},
                     4'b0011, 1, 1, 5, 5, dv(5,0), dv(5,1), 0);
        tbl[6]  = mk(4'b0011, 0, {5'd0,5'd0,5'd5,5'd5}, {6'd0,6'd0,6'd62,6'd1},
                     4'b0011, 1, 1, 5, 5, dv(6,0), dv(6,1), 1);
        tbl[7]  = mk(4'b0011, 1, {5'd0,5'd0,5'd6,5'd6}, {6'd0,6'd0,6'd62,6'd1},
                     4'b0000, 0, 0, 5, 5, dv(6,0), dv(6,1), 0);
        tbl[8]  = mk(4'b0011, 0, {5'd0,5'd0,5'd6,5'd6}, {6'd0,6'd0,6'd1,6'd2},
                     4'b0011, 1, 1, 6, 6, dv(8,0), dv(8,1), 1);
        tbl[9]  = mk(4'b1100, 0, {5'd9,5'd0,5'd6,5'd6}, {6'd5,6'd10,6'd0,6'd0},
                     4'b1100, !DROP, 1, 0, 9, dv(9,2), dv(9,3), !DROP);
        tbl[10] = mk(4'b0000, 0, {5'd9,5'd0,5'd6,5'd6}, {6'd5,6'd10,6'd0,6'd0},
                     4'b0000, 0, 0, 0, 9, dv(9,2), dv(9,3), 0);
        tbl[11] = mk(4'b1000, 0, {5'd4,5'd0,5'd6,5'd6}, {6'd0,6'd0,6'd0,6'd0},
                     4'b1000, 1, 0, 4, 9, dv(11,3), dv(9,3), 0);
        tbl[12] = mk(4'b1010, 0, {5'd4,5'd0,5'd6,5'd6}, {6'd7,6'd0,6'd8,6'd0},
                     4'b1010, 1, 1, 6, 4, dv(12,1), dv(12,3), 1);

        for (int n = 0; n < 13; n++) begin
            bus.src_valid = tbl[n].valid;
            bus.flush     = tbl[n].flush;
            bus.src_dest  = tbl[n].dest;
            bus.src_tag   = tbl[n].tag;
            for (int i = 0; i < N; i++) bus.src_data[i*32 +: 32] = dv(n, i);
            #3 chk($sformatf("v%0d_ready", n), 32'(bus.src_ready), 32'(tbl[n].e_ready));
            @(posedge clk); #1;
            chk_outs(tbl[n].e_ld_a, tbl[n].e_ld_b, tbl[n].e_da, tbl[n].e_db,
                     tbl[n].e_ia, tbl[n].e_ib, tbl[n].e_pref);
        end

        m_rr = 0;
        m_ld_a = tbl[12].e_ld_a; m_ld_b = tbl[12].e_ld_b; m_pref = tbl[12].e_pref;
        m_da = tbl[12].e_da; m_db = tbl[12].e_db; m_ia = tbl[12].e_ia; m_ib = tbl[12].e_ib;

        for (int cyc = 0; cyc < 400; cyc++) begin
            int          dst[N];
            int          tg[N];
            logic [31:0] dat[N];
            logic [3:0]  v;
            logic        f;
            logic [3:0]  exp_ready;
            int          g[$];
            v = 4'($urandom);
            f = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) begin
                dst[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
                tg[i]  = int'($urandom_range(0, 63));
                dat[i] = $urandom;
                bus.src_dest[i*5 +: 5] = 5'(dst[i]);
                bus.src_tag[i*6 +: 6]  = 6'(tg[i]);
                bus.src_data[i*32 +: 32] = dat[i];
            end
            bus.src_valid = v;
            bus.flush     = f;

            // Grants are the first two valid sources in rotation order from m_rr.
            g.delete();
            if (!f) begin
                for (int k = 0; k < N; k++)
                    if (v[(m_rr + k) % N] && g.size() < 2) g.push_back((m_rr + k) % N);
            end
            exp_ready = '0;
            foreach (g[j]) exp_ready[g[j]] = 1'b1;
            #3 chk("rnd_ready", 32'(bus.src_ready), 32'(exp_ready));

            m_ld_a = 1'b0; m_ld_b = 1'b0; m_pref = 1'b0;
            if (g.size() >= 1) begin
                m_ld_a = !(DROP && dst[g[0]] == 0);
                m_da = 5'(dst[g[0]]); m_ia = dat[g[0]];
                m_rr = (g[g.size()-1] + 1) % N;
            end
            if (g.size() == 2) begin
                int d;
                m_ld_b = !(DROP && dst[g[1]] == 0);
                m_db = 5'(dst[g[1]]); m_ib = dat[g[1]];
                d = (tg[g[0]] - tg[g[1]] + 64) % 64;
                m_pref = m_ld_a && m_ld_b && d != 0 && d < 32;
            end
            @(posedge clk); #1;
            chk_outs(m_ld_a, m_ld_b, m_da, m_db, m_ia, m_ib, m_pref);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
